// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add WIDTHxWIDTH unsigned multiplier sequencer driving the shared ALU
// Optional MUL_EARLY_EXIT_EN: finish as soon as the unprocessed multiplier bits are all zero.
module alu_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_f,
  output logic             alu_csel,
  output logic             alu_ucin,
  output logic             alu_not_oe,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout
);
  localparam logic [4:0]       F_ADD    = 5'b10010;
  localparam logic [4:0]       F_PASS_A = 5'b00000;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   p_hi, q, m;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               early_exit;
  logic               add_c;
  logic [WIDTH-1:0]   add_hi;
  logic [2*WIDTH-1:0] pq_nx;

  assign accept = start && (state == S_IDLE || state == S_DONE);

`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0] pending_mask;
  logic [CNT_W:0]   exit_shamt;

  // Bits of Q not yet consumed sit in the low WIDTH-cnt positions.
  assign pending_mask = {WIDTH{1'b1}} >> cnt;
  assign early_exit   = (state == S_RUN) && ((q & pending_mask) == '0);
  assign exit_shamt   = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    add_c  = q[0] ? alu_cout : 1'b0;
    add_hi = q[0] ? alu_y : p_hi;
    // The ALU carry-out lands in P_hi[15] so the full 2*WIDTH product is kept.
    pq_nx  = {add_c, add_hi, q[WIDTH-1:1]};
`ifdef MUL_EARLY_EXIT_EN
    if (early_exit) pq_nx = {p_hi, q} >> exit_shamt;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN:  if (cnt == LAST_CNT || early_exit) state_nx = S_DONE;
      S_DONE: state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      p_hi  <= '0;
      q     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        p_hi <= '0;
        q    <= multiplier;
        m    <= multiplicand;
        cnt  <= '0;
      end else if (state == S_RUN) begin
        {p_hi, q} <= pq_nx;
        cnt       <= cnt + 1'b1;
      end
    end
  end

  assign busy       = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign product_hi = p_hi;
  assign product_lo = q;
  assign alu_a      = p_hi;
  assign alu_b      = m;
  assign alu_f      = (busy && q[0]) ? F_ADD : F_PASS_A;
  assign alu_csel   = 1'b0;
  assign alu_ucin   = 1'b0;
  assign alu_not_oe = !busy;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq against an arithmetic reference
// Honours MUL_EARLY_EXIT_EN for expected latency.
module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] multiplicand, multiplier;
  logic        busy, done;
  logic [15:0] product_hi, product_lo, alu_a, alu_b, alu_y;
  logic [4:0]  alu_f;
  logic        alu_csel, alu_ucin, alu_not_oe, alu_cout;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: ADD or pass A.
  assign {alu_cout, alu_y} = (alu_f == 5'b10010) ? ({1'b0, alu_a} + {1'b0, alu_b}) : {1'b0, alu_a};

  alu_mul_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_csel(alu_csel), .alu_ucin(alu_ucin),
    .alu_not_oe(alu_not_oe), .alu_y(alu_y), .alu_cout(alu_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Number of RUN cycles before done is seen.
  function automatic int exp_latency(input logic [15:0] qq);
`ifdef MUL_EARLY_EXIT_EN
    int msb = -1;
    for (int i = 0; i < 16; i++) if (qq[i]) msb = i;
    return msb + 2;
`else
    return 16;
`endif
  endfunction

  // Samples taken #1 after each edge starting with the accepting edge; stops at done.
  task automatic watch_run(input logic [15:0] mm, input logic [15:0] qq, input bit scramble,
                           output bit seen);
    int busy_n = 0;
    int lat = 0;
    logic [4:0] exp_f;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
      if (busy) begin
        busy_n++;
        exp_f = (i < 16 && qq[i]) ? 5'b10010 : 5'b00000;
        chk("alu_f_run", {27'd0, alu_f}, {27'd0, exp_f});
        chk("not_oe_run", {31'd0, alu_not_oe}, 32'd0);
        if (i == 0) chk("alu_b_m", {16'd0, alu_b}, {16'd0, mm});
      end
      if (scramble) begin
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", lat, exp_latency(qq));
    chk("busy_cycles", busy_n, exp_latency(qq));
    chk("product", {product_hi, product_lo}, 32'(mm) * 32'(qq));
  endtask

  task automatic run_op(input logic [15:0] mm, input logic [15:0] qq);
    bit seen;
    @(negedge clk);
    multiplicand = mm;
    multiplier   = qq;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    watch_run(mm, qq, 1'b1, seen);
    @(posedge clk); #1;
    chk("idle_done_low", {31'd0, done}, 32'd0);
    chk("idle_busy_low", {31'd0, busy}, 32'd0);
    chk("idle_product_held", {product_hi, product_lo}, 32'(mm) * 32'(qq));
  endtask

  initial begin
    bit seen, saw_done;
    logic [15:0] m2, q2;
    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_not_oe", {31'd0, alu_not_oe}, 32'd1);
    chk("rst_alu_f", {27'd0, alu_f}, 32'd0);
    chk("rst_product", {product_hi, product_lo}, 32'd0);
    chk("rst_csel_ucin", {30'd0, alu_csel, alu_ucin}, 32'd0);

    run_op(16'h0003, 16'h0005);
    run_op(16'hFFFF, 16'hFFFF);
    run_op(16'h8000, 16'h0002);
    run_op(16'h0007, 16'h0001);
    run_op(16'h1234, 16'h0000);
    run_op(16'h0000, 16'hABCD);
    run_op(16'hFFFF, 16'h8000);
    for (int k = 0; k < 20; k++) run_op(16'($urandom), 16'($urandom));

    // Reset during RUN cycle 7 aborts with no result.
    @(negedge clk);
    multiplicand = 16'h1234; multiplier = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {product_hi, product_lo}, 32'd0);
    chk("abort_not_oe", {31'd0, alu_not_oe}, 32'd1);
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);

    // Start held high: ignored while busy, restarts directly from DONE.
    @(negedge clk);
    multiplicand = 16'h0003; multiplier = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    watch_run(16'h0003, 16'h0005, 1'b1, seen);
    m2 = 16'($urandom);
    q2 = 16'($urandom) | 16'h8000;
    multiplicand = m2;
    multiplier   = q2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    watch_run(m2, q2, 1'b1, seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
